// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : timer_pkg
//  Desc     : Shared constants, types and helpers for the timer APB register
//             block: address map, TCR/TSR bit positions, APB FSM encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

    // Register index: the map occupies the bottom four addresses.
    localparam logic [1:0] c_addr_tdr  = 2'd0;
    localparam logic [1:0] c_addr_tcr  = 2'd1;
    localparam logic [1:0] c_addr_tsr  = 2'd2;
    localparam logic [1:0] c_addr_tcnt = 2'd3;

    // TCR bit positions
    localparam int c_tcr_load   = 7;
    localparam int c_tcr_down   = 5;
    localparam int c_tcr_en     = 4;
    localparam int c_tcr_cks_hi = 1;
    localparam int c_tcr_cks_lo = 0;

    // Only implemented TCR bits are stored; reserved bits read back as 0.
    localparam logic [7:0] c_tcr_wmask = 8'hB3;

    // TSR bit positions
    localparam int c_tsr_ovf = 0;
    localparam int c_tsr_udf = 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // An access errors when it falls outside the map or writes the read-only
    // counter snapshot.
    function automatic logic access_err(input logic       in_range,
                                        input logic [1:0] reg_sel,
                                        input logic       is_write);
        return !in_range || (is_write && (reg_sel == c_addr_tcnt));
    endfunction

endpackage
`default_nettype wire

// File: rtl/timer_apb_regs_if.sv
`default_nettype none
// ============================================================================
//  Module   : timer_apb_regs_if
//  Desc     : APB bus bundle between the CPU-side master and the timer
//             register block.
//  Revision : 1.0 - initial release
// ============================================================================
interface timer_apb_regs_if #(
    parameter int ADDR_W = 8
) ();

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [7:0]        pwdata;
    logic [7:0]        prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );

endinterface
`default_nettype wire

// File: rtl/apb_slave_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : apb_slave_fsm
//  Desc     : APB responder handshake: SETUP/ACCESS sequencing, wait-state
//             counter, registered pready/pslverr and the read/write strobes
//             used by the register file.
//  Revision : 1.0 - initial release
// ============================================================================
module apb_slave_fsm
    import timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 8
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              i_psel,
    input  wire logic              i_penable,
    input  wire logic              i_pwrite,
    input  wire logic [ADDR_W-1:0] i_paddr,
    output logic                   o_pready,
    output logic                   o_pslverr,
    output logic                   o_wr_en,
    output logic                   o_rd_en
);

    // Wait counter value at which pready is scheduled for the next cycle.
    localparam logic [1:0] c_last_wait = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;
    localparam logic       c_no_wait   = (WAIT_CYCLES == 0);

    apb_state_e r_state;
    apb_state_e w_state_nxt;
    logic [1:0] r_wait_cnt;
    logic [1:0] w_wait_cnt_nxt;
    logic       r_pready;
    logic       w_pready_nxt;
    logic       r_pslverr;
    logic       w_in_range;
    logic       w_err;

    assign w_in_range = ((i_paddr >> 2) == '0);
    assign w_err      = access_err(w_in_range, i_paddr[1:0], i_pwrite);

    // Next-state logic; pready is computed one cycle early so it can be registered.
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_pready_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_psel && !i_penable) begin
                    w_state_nxt    = ST_SETUP;
                    w_wait_cnt_nxt = 2'd0;
                end
            end
            ST_SETUP: begin
                if (i_psel && i_penable) begin
                    w_state_nxt  = ST_ACCESS;
                    w_pready_nxt = c_no_wait;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                // Completion, deselect or a dropped penable all end the transfer.
                if (r_pready || !i_psel || !i_penable) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_wait_cnt == c_last_wait) begin
                    w_pready_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, wait counter and registered response flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 2'd0;
            r_pready   <= 1'b0;
            r_pslverr  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_pready   <= w_pready_nxt;
            r_pslverr  <= w_pready_nxt && w_err;
        end
    end

    assign o_pready  = r_pready;
    assign o_pslverr = r_pslverr;
    // pready is only ever high in ACCESS, so it also qualifies the state.
    assign o_wr_en   = r_pready && i_psel && i_penable && i_pwrite && !w_err;
    // Read data is captured on the edge that raises pready.
    assign o_rd_en   = w_pready_nxt && !i_pwrite && !w_err;

endmodule
`default_nettype wire

// File: rtl/timer_apb_regs.sv
`default_nettype none
// ============================================================================
//  Module   : timer_apb_regs
//  Desc     : APB register file for the 8-bit timer: TDR, TCR and TSR, plus
//             read-only access to the live counter value.
//  Revision : 1.0 - initial release
// ============================================================================
module timer_apb_regs
    import timer_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 8
) (
    input  wire logic           pclk,
    input  wire logic           presetn,
    timer_apb_regs_if.slave     apb,
    output logic [7:0]          tdr,
    output logic                tcr_load,
    output logic                tcr_down,
    output logic                tcr_en,
    output logic [1:0]          tcr_cks,
    input  wire logic           ovf_set,
    input  wire logic           udf_set,
    input  wire logic [7:0]     tcnt,
    output logic                tsr_ovf,
    output logic                tsr_udf
);

    logic [7:0] r_tdr;
    logic [7:0] r_tcr;
    logic [1:0] r_tsr;
    logic [1:0] w_tsr_nxt;
    logic [1:0] w_tsr_set;
    logic [1:0] w_tsr_clr;
    logic [7:0] r_prdata;
    logic [7:0] w_rdata;
    logic [1:0] w_reg_sel;
    logic       w_wr_en;
    logic       w_rd_en;
    logic       w_pready;
    logic       w_pslverr;

    apb_slave_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .ADDR_W      (ADDR_W)
    ) u_fsm (
        .clk       (pclk),
        .rst_n     (presetn),
        .i_psel    (apb.psel),
        .i_penable (apb.penable),
        .i_pwrite  (apb.pwrite),
        .i_paddr   (apb.paddr),
        .o_pready  (w_pready),
        .o_pslverr (w_pslverr),
        .o_wr_en   (w_wr_en),
        .o_rd_en   (w_rd_en)
    );

    assign w_reg_sel = apb.paddr[1:0];

    // Read multiplexer over the register map.
    always_comb begin
        w_rdata = 8'h00;
        unique case (w_reg_sel)
            c_addr_tdr:  w_rdata = r_tdr;
            c_addr_tcr:  w_rdata = r_tcr;
            c_addr_tsr:  w_rdata = {6'b000000, r_tsr};
            c_addr_tcnt: w_rdata = tcnt;
            default:     w_rdata = 8'h00;
        endcase
    end

    // TSR: a core pulse sets a bit, a 0 in the written data clears it; set wins.
    assign w_tsr_set[c_tsr_ovf] = ovf_set;
    assign w_tsr_set[c_tsr_udf] = udf_set;
    assign w_tsr_clr = (w_wr_en && (w_reg_sel == c_addr_tsr)) ? ~apb.pwdata[1:0] : 2'b00;

    for (genvar gi = 0; gi < 2; gi++) begin : g_tsr_bit
        assign w_tsr_nxt[gi] = w_tsr_set[gi] | (r_tsr[gi] & ~w_tsr_clr[gi]);
    end

    // Register file and read-data capture.
    always_ff @(posedge pclk) begin
        if (!presetn) begin
            r_tdr    <= 8'h00;
            r_tcr    <= 8'h00;
            r_tsr    <= 2'b00;
            r_prdata <= 8'h00;
        end else begin
            if (w_wr_en && (w_reg_sel == c_addr_tdr)) begin
                r_tdr <= apb.pwdata;
            end
            if (w_wr_en && (w_reg_sel == c_addr_tcr)) begin
                r_tcr <= apb.pwdata & c_tcr_wmask;
            end
            r_tsr    <= w_tsr_nxt;
            r_prdata <= w_rd_en ? w_rdata : 8'h00;
        end
    end

    assign apb.prdata  = r_prdata;
    assign apb.pready  = w_pready;
    assign apb.pslverr = w_pslverr;

    assign tdr      = r_tdr;
    assign tcr_load = r_tcr[c_tcr_load];
    assign tcr_down = r_tcr[c_tcr_down];
    assign tcr_en   = r_tcr[c_tcr_en];
    assign tcr_cks  = r_tcr[c_tcr_cks_hi:c_tcr_cks_lo];
    assign tsr_ovf  = r_tsr[c_tsr_ovf];
    assign tsr_udf  = r_tsr[c_tsr_udf];

endmodule
`default_nettype wire

// File: doc/timer_apb_regs.md
Name: timer_apb_regs

Overview:
APB responder and register file for the 8-bit timer: decodes CPU APB reads and writes and holds TDR, TCR and TSR. Drives control fields to the counter core and captures the overflow/underflow events it reports. Sits between the APB bus (CPU side) and the timer counter core; clocked on pclk.

Parameters:
WAIT_CYCLES, 0, extra wait states inserted in the ACCESS phase before pready (0..3)
ADDR_W, 8, APB address width

Ports:
pclk  in  1  APB/system clock
presetn  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (ACCESS phase)
pwrite  in  1  1 = write, 0 = read
paddr  in  ADDR_W  register address
pwdata  in  8  write data
prdata  out  8  read data, valid while pready=1 on a read
pready  out  1  transfer complete
pslverr  out  1  error response, valid while pready=1
tdr  out  8  load/compare value to counter core
tcr_load  out  1  TCR[7], load TDR into counter
tcr_down  out  1  TCR[5], 1 = count down, 0 = count up
tcr_en  out  1  TCR[4], count enable
tcr_cks  out  2  TCR[1:0], clock select (00 clk2, 01 clk4, 10 clk8, 11 clk16)
ovf_set  in  1  one-cycle pulse from core: overflow occurred
udf_set  in  1  one-cycle pulse from core: underflow occurred
tcnt  in  8  live counter value, read-only at 0x03
tsr_ovf  out  1  TSR[0] to interrupt logic
tsr_udf  out  1  TSR[1] to interrupt logic

Behaviour:
- Reset: all synchronous on pclk when presetn=0. State=IDLE; tdr=0x00, TCR=0x00, TSR=0x00; prdata=0x00, pready=0, pslverr=0; wait counter=0.
- Address map: 0x00 TDR (RW), 0x01 TCR (RW, bits 6,3,2 reserved: write ignored, read 0), 0x02 TSR (RW0C, bits 7:2 read 0), 0x03 TCNT (RO). Any other address is invalid.
- FSM states:
  - IDLE -> SETUP when psel=1 and penable=0.
  - SETUP -> ACCESS on the next cycle, required penable=1.
  - ACCESS holds for WAIT_CYCLES cycles with pready=0. On the following cycle pready=1 for exactly one cycle, then -> IDLE.
  - A new SETUP may be accepted in the cycle right after pready.
- Latency: pready rises WAIT_CYCLES+1 cycles after the first penable=1 cycle. With WAIT_CYCLES=0, a transfer takes 3 cycles, and pready is registered.
- Write commit: the register updates on the pclk edge where psel=penable=pready=1 and pwrite=1.
- Read data: prdata is sampled from the register or tcnt in the last wait cycle, held while pready=1, and is 0x00 otherwise.
- pslverr=1 with pready when:
  - the address is invalid (read or write), or
  - the access is a write to 0x03.
  In both cases no register changes and prdata=0x00.
- TSR bits:
  - Set by ovf_set/udf_set.
  - A write clears each bit whose pwdata bit is 0; a pwdata bit of 1 has no effect (0x00 clears both, 0x03 clears neither).
  - Same-cycle set pulse and clear write: set wins, the bit stays 1.
  - Set pulse while the bit is already 1: stays 1.
- Abort: psel dropping in SETUP/ACCESS before pready -> IDLE, no commit, pready stays 0.
- Protocol violation: penable=0 in ACCESS -> treated as an abort.
- Reset mid-transfer: presetn=0 at any state forces full reset next edge; the transfer is lost.
- Outputs tdr/tcr_* are direct register bits: they change the cycle after the commit edge, with no extra pipelining.

Decomposition:
- Shared package (timer_pkg): address constants ADDR_TDR/TCR/TSR/TCNT, TCR bit indices (LOAD=7, DOWN=5, EN=4, CKS=1:0), TSR bit indices (OVF=0, UDF=1), FSM state encoding, TCR writable mask 0xB3.
- One sub-module, apb_slave_fsm: handles psel/penable/pready/wait counter and outputs wr_en/rd_en/err strobes. The register file stays in timer_apb_regs.

Test Plan:
- After reset: read 0x00, 0x01, 0x02 -> prdata 0x00, pslverr=0, pready asserted WAIT_CYCLES+1 cycles after penable.
- Write 0x01<=0x12 then read 0x01 -> 0x12; tcr_en=1, tcr_cks=2'b10, tcr_down=0, tcr_load=0. Write 0x01<=0xFF -> read 0xB3.
- Pulse ovf_set then read 0x02 -> 0x01. Write 0x02<=0x00, read -> 0x00. Pulse udf_set, write 0x02<=0x02 -> read 0x02 (bit kept).
- ovf_set pulsed on the same edge as a write 0x02<=0x00 commit -> read 0x02 returns 0x01.
- Read 0x05 -> pslverr=1, prdata=0x00. Write 0x03<=0x55 -> pslverr=1, no register change. Drive tcnt=0xA7 and read 0x03 -> 0xA7, pslverr=0.
- Write 0x00<=0x5A, with presetn low in ACCESS before pready -> TDR reads 0x00 after reset and pready never pulses for the aborted transfer.
